// File: rtl/agu_cluster_pkg.sv
// Shared constants and small helpers for the agu_cluster address-generation stage.
// Op encoding: [1:0] log2 access size, [5] store.
package agu_cluster_pkg;

  localparam int OP_SIZE_LSB = 0;
  localparam int OP_SIZE_W   = 2;
  localparam int OP_STORE    = 5;
  localparam int OP_W        = OP_STORE + 1;
  localparam int SCALE_W     = 2;
  localparam int RW_DEF      = 6;
  localparam int LINE_LG_DEF = 6;
  localparam int ZERO_REG    = 0;

  typedef logic [OP_W-1:0]      op_t;
  typedef logic [SCALE_W-1:0]   scale_t;
  typedef logic [OP_SIZE_W-1:0] size_t;

  function automatic size_t op_size(input op_t op);
    return op[OP_SIZE_LSB +: OP_SIZE_W];
  endfunction

endpackage

// File: rtl/agu_lane.sv
// One load/store channel: skid (_p0), S0 (_p1) and S1 (_p2) registers, writeback snoop
// for late operands, effective-address adder and line-crossing detection.
module agu_lane
  import agu_cluster_pkg::*;
#(
  parameter int AW      = 64,
  parameter int DW      = 65,
  parameter int NBYP    = 6,
  parameter int RW      = RW_DEF,
  parameter int LINE_LG = LINE_LG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic             advance,
  input  logic             accept,
  input  op_t              op,
  input  logic [RW-1:0]    basereg,
  input  logic [RW-1:0]    indexreg,
  input  logic [DW-1:0]    base,
  input  logic [DW-1:0]    index,
  input  logic             base_rdy,
  input  logic             index_rdy,
  input  scale_t           scale,
  input  logic [DW-1:0]    offset,
  input  logic [RW-1:0]    rt,
  input  logic [NBYP-1:0]      byp_wen,
  input  logic [NBYP*RW-1:0]   byp_rt,
  input  logic [NBYP*DW-1:0]   byp_data,
  output logic             blocked,
  output logic             skid_nxt,
  output logic             out_en,
  output logic [AW-1:0]    out_addr,
  output op_t              out_op,
  output logic [RW-1:0]    out_rt,
  output logic             out_split
);

  typedef struct packed {
    logic          rdy;
    logic [AW-1:0] data;
  } opnd_t;

  // Tag bit and upper data bits never contribute to the address.
  logic unused_tags;
  assign unused_tags = ^{base, index, offset, byp_data};

  // Lowest-numbered matching bus wins, so scan from the top down.
  function automatic opnd_t snoop(input logic [RW-1:0] r, input opnd_t cur);
    opnd_t res;
    res = cur;
    if (!cur.rdy && r != RW'(ZERO_REG)) begin
      for (int b = NBYP - 1; b >= 0; b--) begin
        if (byp_wen[b] && byp_rt[b*RW +: RW] == r) begin
          res.rdy  = 1'b1;
          res.data = byp_data[b*DW +: AW];
        end
      end
    end
    return res;
  endfunction

  function automatic opnd_t capture(input logic [RW-1:0] r, input logic [AW-1:0] d,
                                    input logic rdy);
    opnd_t res;
    if (r == RW'(ZERO_REG)) begin
      res.rdy  = 1'b1;
      res.data = '0;
    end else begin
      res.rdy  = rdy;
      res.data = d;
      res      = snoop(r, res);
    end
    return res;
  endfunction

  function automatic logic [AW-1:0] eff_addr(input logic [AW-1:0] b, input logic [AW-1:0] ix,
                                             input scale_t sc, input logic [AW-1:0] off);
    return b + (ix << sc) + off;
  endfunction

  function automatic logic line_split(input logic [LINE_LG-1:0] lo, input size_t sz);
    logic [LINE_LG+4:0] sum;
    sum = (LINE_LG+5)'(lo) + ((LINE_LG+5)'(1) << sz);
    return sum > ((LINE_LG+5)'(1) << LINE_LG);
  endfunction

  logic             vld_p0, vld_p1;
  op_t              op_p0, op_p1;
  logic [RW-1:0]    rt_p0, rt_p1;
  scale_t           scale_p0, scale_p1;
  logic [AW-1:0]    off_p0, off_p1;
  logic [RW-1:0]    breg_p0, breg_p1, ireg_p0, ireg_p1;
  opnd_t            b_p0, b_p1, i_p0, i_p1;

  opnd_t            b_in, i_in, b_sk, i_sk, b_s0, i_s0;
  logic [AW-1:0]    addr_s0;
  logic             split_s0;

  always_comb begin
    b_in = capture(basereg, base[AW-1:0], base_rdy);
    i_in = capture(indexreg, index[AW-1:0], index_rdy);
    b_sk = snoop(breg_p0, b_p0);
    i_sk = snoop(ireg_p0, i_p0);
    b_s0 = snoop(breg_p1, b_p1);
    i_s0 = snoop(ireg_p1, i_p1);
  end

  assign blocked  = vld_p1 & ~(b_p1.rdy & i_p1.rdy);
  assign skid_nxt = (vld_p0 | accept) & ~advance & ~flush;
  assign addr_s0  = eff_addr(b_p1.data, i_p1.data, scale_p1, off_p1);
  assign split_s0 = line_split(addr_s0[LINE_LG-1:0], op_size(op_p1));

  // Skid (_p0) and S0 (_p1) payload; waiting operands keep snooping while held.
  always_ff @(posedge clk) begin
    if (accept && !advance) begin
      op_p0    <= op;
      rt_p0    <= rt;
      scale_p0 <= scale;
      off_p0   <= offset[AW-1:0];
      breg_p0  <= basereg;
      ireg_p0  <= indexreg;
      b_p0     <= b_in;
      i_p0     <= i_in;
    end else begin
      b_p0 <= b_sk;
      i_p0 <= i_sk;
    end

    if (advance) begin
      if (vld_p0) begin
        op_p1    <= op_p0;
        rt_p1    <= rt_p0;
        scale_p1 <= scale_p0;
        off_p1   <= off_p0;
        breg_p1  <= breg_p0;
        ireg_p1  <= ireg_p0;
        b_p1     <= b_sk;
        i_p1     <= i_sk;
      end else begin
        op_p1    <= op;
        rt_p1    <= rt;
        scale_p1 <= scale;
        off_p1   <= offset[AW-1:0];
        breg_p1  <= basereg;
        ireg_p1  <= indexreg;
        b_p1     <= b_in;
        i_p1     <= i_in;
      end
    end else begin
      b_p1 <= b_s0;
      i_p1 <= i_s0;
    end
  end

  // The skid is only ever filled while do_stall is low, so skid and a new accept never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= skid_nxt;
      if (flush)        vld_p1 <= 1'b0;
      else if (advance) vld_p1 <= vld_p0 | accept;
    end
  end

  // S1 (_p2): holds only under stall; a blocked S0 without stall sends a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_en    <= 1'b0;
      out_addr  <= '0;
      out_op    <= '0;
      out_rt    <= '0;
      out_split <= 1'b0;
    end else if (flush) begin
      out_en <= 1'b0;
    end else if (advance) begin
      out_en    <= vld_p1;
      out_addr  <= addr_s0;
      out_op    <= op_p1;
      out_rt    <= rt_p1;
      out_split <= split_s0;
    end else if (!stall) begin
      out_en <= 1'b0;
    end
  end

endmodule

// File: rtl/agu_cluster.sv
// N-channel address-generation stage: per-channel lanes advancing in lockstep,
// with registered backpressure (do_stall) toward issue.
module agu_cluster
  import agu_cluster_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int AW      = 64,
  parameter int DW      = 65,
  parameter int NBYP    = 6,
  parameter int RW      = RW_DEF,
  parameter int LINE_LG = LINE_LG_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 do_stall,
  input  logic [NCH-1:0]       in_en,
  input  logic [NCH*OP_W-1:0]  in_op,
  input  logic [NCH*RW-1:0]    in_basereg,
  input  logic [NCH*RW-1:0]    in_indexreg,
  input  logic [NCH*DW-1:0]    in_base,
  input  logic [NCH*DW-1:0]    in_index,
  input  logic [NCH-1:0]       in_base_rdy,
  input  logic [NCH-1:0]       in_index_rdy,
  input  logic [NCH*2-1:0]     in_scale,
  input  logic [NCH*DW-1:0]    in_offset,
  input  logic [NCH*RW-1:0]    in_rT,
  input  logic [NBYP-1:0]      byp_wen,
  input  logic [NBYP*RW-1:0]   byp_rT,
  input  logic [NBYP*DW-1:0]   byp_data,
  output logic [NCH-1:0]       out_en,
  output logic [NCH*AW-1:0]    out_addr,
  output logic [NCH*OP_W-1:0]  out_op,
  output logic [NCH*RW-1:0]    out_rT,
  output logic [NCH-1:0]       out_split
);

  logic [NCH-1:0] blocked;
  logic [NCH-1:0] skid_nxt;
  logic [NCH-1:0] accept;
  logic           advance;

  // One channel with an unready S0 operand holds every channel.
  assign advance = ~stall & ~flush & ~(|blocked);
  assign accept  = in_en & {NCH{~do_stall & ~flush}};

  always_ff @(posedge clk) begin
    if (rst) do_stall <= 1'b0;
    else     do_stall <= |skid_nxt;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    agu_lane #(
      .AW      (AW),
      .DW      (DW),
      .NBYP    (NBYP),
      .RW      (RW),
      .LINE_LG (LINE_LG)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .stall     (stall),
      .advance   (advance),
      .accept    (accept[g]),
      .op        (in_op[g*OP_W +: OP_W]),
      .basereg   (in_basereg[g*RW +: RW]),
      .indexreg  (in_indexreg[g*RW +: RW]),
      .base      (in_base[g*DW +: DW]),
      .index     (in_index[g*DW +: DW]),
      .base_rdy  (in_base_rdy[g]),
      .index_rdy (in_index_rdy[g]),
      .scale     (in_scale[g*2 +: 2]),
      .offset    (in_offset[g*DW +: DW]),
      .rt        (in_rT[g*RW +: RW]),
      .byp_wen   (byp_wen),
      .byp_rt    (byp_rT),
      .byp_data  (byp_data),
      .blocked   (blocked[g]),
      .skid_nxt  (skid_nxt[g]),
      .out_en    (out_en[g]),
      .out_addr  (out_addr[g*AW +: AW]),
      .out_op    (out_op[g*OP_W +: OP_W]),
      .out_rt    (out_rT[g*RW +: RW]),
      .out_split (out_split[g])
    );
  end

endmodule

// File: tb/tb_agu_cluster.sv
// Directed bench for agu_cluster: address math, line split, bypass priority,
// stall/skid ordering, zero register and flush.
module tb_agu_cluster;

  localparam int NCH = 3, AW = 64, DW = 65, NBYP = 6, RW = 6, LINE_LG = 6;

  logic clk = 1'b0;
  logic rst, stall, flush, do_stall;
  logic [NCH-1:0]      in_en, in_base_rdy, in_index_rdy, out_en, out_split;
  logic [NCH*6-1:0]    in_op, out_op;
  logic [NCH*RW-1:0]   in_basereg, in_indexreg, in_rT, out_rT;
  logic [NCH*DW-1:0]   in_base, in_index, in_offset;
  logic [NCH*2-1:0]    in_scale;
  logic [NBYP-1:0]     byp_wen;
  logic [NBYP*RW-1:0]  byp_rT;
  logic [NBYP*DW-1:0]  byp_data;
  logic [NCH*AW-1:0]   out_addr;

  int errs = 0;
  int nchk = 0;
  int k;
  logic [63:0] got[$];

  always #5 clk = ~clk;

  agu_cluster #(.NCH(NCH), .AW(AW), .DW(DW), .NBYP(NBYP), .RW(RW), .LINE_LG(LINE_LG)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .do_stall(do_stall),
    .in_en(in_en), .in_op(in_op), .in_basereg(in_basereg), .in_indexreg(in_indexreg),
    .in_base(in_base), .in_index(in_index), .in_base_rdy(in_base_rdy),
    .in_index_rdy(in_index_rdy), .in_scale(in_scale), .in_offset(in_offset), .in_rT(in_rT),
    .byp_wen(byp_wen), .byp_rT(byp_rT), .byp_data(byp_data),
    .out_en(out_en), .out_addr(out_addr), .out_op(out_op), .out_rT(out_rT),
    .out_split(out_split)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic [5:0] op,
                       input logic [RW-1:0] br, input logic [63:0] b, input logic brdy,
                       input logic [RW-1:0] ir, input logic [63:0] ix, input logic irdy,
                       input logic [1:0] sc, input logic [63:0] off, input logic [RW-1:0] rt);
    in_en[ch]              = 1'b1;
    in_op[ch*6 +: 6]       = op;
    in_basereg[ch*RW +: RW]  = br;
    in_base[ch*DW +: DW]     = {1'b1, b};
    in_base_rdy[ch]          = brdy;
    in_indexreg[ch*RW +: RW] = ir;
    in_index[ch*DW +: DW]    = {1'b1, ix};
    in_index_rdy[ch]         = irdy;
    in_scale[ch*2 +: 2]      = sc;
    in_offset[ch*DW +: DW]   = {1'b1, off};
    in_rT[ch*RW +: RW]       = rt;
  endtask

  task automatic bus(input int b, input logic [RW-1:0] r, input logic [63:0] d);
    byp_wen[b]          = 1'b1;
    byp_rT[b*RW +: RW]  = r;
    byp_data[b*DW +: DW] = {1'b1, d};
  endtask

  function automatic logic [63:0] addr_of(input int ch);
    return out_addr[ch*AW +: AW];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    in_en = '0; in_op = '0; in_basereg = '0; in_indexreg = '0; in_base = '0; in_index = '0;
    in_base_rdy = '0; in_index_rdy = '0; in_scale = '0; in_offset = '0; in_rT = '0;
    byp_wen = '0; byp_rT = '0; byp_data = '0;
    repeat (3) tick();
    chk("rst_en", out_en, 0);
    chk("rst_dstall", do_stall, 0);
    chk("rst_addr", out_addr[63:0], 0);
    chk("rst_op", out_op, 0);
    chk("rst_rt", out_rT, 0);
    chk("rst_split", out_split, 0);
    rst = 1'b0;

    // Basic scaled address, two-cycle latency
    drive(0, 6'h03, 6'd1, 64'h1000, 1'b1, 6'd2, 64'h10, 1'b1, 2'd3, 64'h8, 6'd7);
    tick(); in_en = '0;
    chk("t1_latency", out_en, 0);
    tick();
    chk("t1_en", out_en, 3'b001);
    chk("t1_addr", addr_of(0), 64'h1088);
    chk("t1_split", out_split, 0);
    chk("t1_op", out_op[5:0], 6'h03);
    chk("t1_rt", out_rT[5:0], 6'd7);
    tick();
    chk("t1_drain", out_en, 0);

    // Line crossing: size 8 at 0x103C splits, size 4 does not
    drive(0, 6'h03, 6'd1, 64'h103C, 1'b1, 6'd3, 64'h0, 1'b1, 2'd0, 64'h0, 6'd1);
    drive(2, 6'h02, 6'd1, 64'h103C, 1'b1, 6'd3, 64'h0, 1'b1, 2'd0, 64'h0, 6'd2);
    tick(); in_en = '0;
    tick();
    chk("t2_en", out_en, 3'b101);
    chk("t2_split", out_split, 3'b001);
    chk("t2_addr2", addr_of(2), 64'h103C);
    tick();

    // Late base operand on channel 1, two buses hit r5; bus 2 has priority
    drive(1, 6'h03, 6'd5, 64'hDEAD, 1'b0, 6'd6, 64'h4, 1'b1, 2'd0, 64'h100, 6'd9);
    tick(); in_en = '0;
    chk("t3_wait_en", out_en, 0);
    chk("t3_wait_ds", do_stall, 0);
    tick();
    bus(1, 6'd9, 64'hCC); bus(2, 6'd5, 64'hA0); bus(4, 6'd5, 64'hB0);
    chk("t3_bubble", out_en, 0);
    tick(); byp_wen = '0;
    chk("t3_bubble2", out_en, 0);
    tick();
    chk("t3_en", out_en, 3'b010);
    chk("t3_addr", addr_of(1), 64'h1A4);
    chk("t3_rt", out_rT[11:6], 6'd9);
    tick();
    chk("t3_drain", out_en, 0);

    // Register 0 ignores read data; same-cycle bypass for an arriving operand
    drive(2, 6'h00, 6'd0, 64'hFFFF, 1'b1, 6'd4, 64'h20, 1'b1, 2'd2, 64'h11, 6'd3);
    drive(1, 6'h01, 6'd0, 64'h5555, 1'b0, 6'd9, 64'h1234, 1'b0, 2'd1, 64'h0, 6'd4);
    bus(0, 6'd9, 64'h40); bus(3, 6'd0, 64'h777);
    tick(); in_en = '0; byp_wen = '0;
    tick();
    chk("t5_en", out_en, 3'b110);
    chk("t5_addr2", addr_of(2), 64'h91);
    chk("t5_addr1", addr_of(1), 64'h80);
    tick();

    // Stall for three cycles while issue presents an op whenever allowed
    k = 0;
    got.delete();
    for (int cyc = 0; cyc < 20; cyc++) begin
      stall = (cyc >= 3 && cyc <= 5);
      if (out_en[0] && !stall) got.push_back(addr_of(0));
      if (cyc == 4) chk("t4_dstall_hi", do_stall, 1);
      if (cyc == 8) chk("t4_dstall_lo", do_stall, 0);
      in_en = '0;
      if (!do_stall && k < 8) begin
        drive(0, 6'h03, 6'd0, 64'h0, 1'b1, 6'd0, 64'h0, 1'b1, 2'd0, 64'h100 * (k + 1), 6'(k));
        k++;
      end
      tick();
    end
    stall = 1'b0; in_en = '0;
    chk("t4_count", got.size(), 8);
    for (int j = 0; j < 8; j++)
      chk("t4_order", (j < got.size()) ? got[j] : 64'h0, 64'h100 * (j + 1));

    // Flush with S1, S0 and skid all occupied under stall
    drive(0, 6'h03, 6'd0, 64'h0, 1'b1, 6'd0, 64'h0, 1'b1, 2'd0, 64'h500, 6'd1);
    tick();
    drive(0, 6'h03, 6'd0, 64'h0, 1'b1, 6'd0, 64'h0, 1'b1, 2'd0, 64'h600, 6'd2);
    tick();
    stall = 1'b1;
    drive(0, 6'h03, 6'd0, 64'h0, 1'b1, 6'd0, 64'h0, 1'b1, 2'd0, 64'h700, 6'd3);
    tick(); in_en = '0;
    chk("t6_held_en", out_en, 3'b001);
    chk("t6_held_addr", addr_of(0), 64'h500);
    chk("t6_pre_ds", do_stall, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    chk("t6_flush_en", out_en, 0);
    chk("t6_flush_ds", do_stall, 0);
    tick(); tick();
    chk("t6_dropped", out_en, 0);
    drive(0, 6'h02, 6'd0, 64'h0, 1'b1, 6'd0, 64'h0, 1'b1, 2'd0, 64'h900, 6'd5);
    tick(); in_en = '0;
    tick();
    chk("t6_after_en", out_en, 3'b001);
    chk("t6_after_addr", addr_of(0), 64'h900);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
